// File: rtl/bcd_down_timer_if.sv
// Control/status bundle for the BCD down-timer. The master drives the requests;
// the slave (the timer) returns the count and the status pulses.
interface bcd_down_timer_if #(parameter int DIGITS = 2);
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  start;
  logic                  abort;
  logic                  en;
  logic                  auto;
  logic [4*DIGITS-1:0]   cnt;
  logic                  busy;
  logic                  done;
  logic                  bout;
  logic                  err;

  modport master (output load, load_val, start, abort, en, auto,
                  input  cnt, busy, done, bout, err);
  modport slave  (input  load, load_val, start, abort, en, auto,
                  output cnt, busy, done, bout, err);
endinterface

// File: rtl/bcd_down_timer.sv
// Loadable multi-digit BCD down-counter with an IDLE/RUN/FIN FSM,
// optional auto-reload on terminal count, and registered status pulses.
module bcd_down_timer_digit (
  input  logic [3:0] i_d,
  input  logic       i_bin,
  output logic [3:0] o_d,
  output logic       o_bout
);
  always_comb begin
    o_d    = i_d;
    o_bout = 1'b0;
    if (i_bin) begin
      if (i_d == 4'd0) begin
        o_d    = 4'd9;
        o_bout = 1'b1;
      end else begin
        o_d = i_d - 4'd1;
      end
    end
  end
endmodule

module bcd_down_timer #(
  parameter int DIGITS = 2
) (
  input  logic             clk,
  input  logic             rstn,
  bcd_down_timer_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t                  r_state, w_state_nxt;
  logic [DIGITS-1:0][3:0]  r_cnt, r_rld, w_cnt_nxt, w_rld_nxt, w_load_d, w_dec;
  logic [DIGITS:0]         w_brw;
  logic                    r_busy, r_done, r_bout, r_err;
  logic                    w_load_ok, w_cnt_one, w_bout_nxt, w_err_nxt;

  assign w_load_d  = bus.load_val;
  assign w_cnt_one = (r_cnt == (4*DIGITS)'(1));
  assign w_brw[0]  = 1'b1;

  // Ripple-borrow chain, one decrement cell per digit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_down_timer_digit u_dig (
      .i_d    (r_cnt[g]),
      .i_bin  (w_brw[g]),
      .o_d    (w_dec[g]),
      .o_bout (w_brw[g+1])
    );
  end

  always_comb begin
    w_load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (w_load_d[i] > 4'd9) w_load_ok = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rld   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bout  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rld   <= w_rld_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_FIN);
      r_bout  <= w_bout_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rld_nxt   = r_rld;
    w_bout_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.load) begin
          if (w_load_ok) begin
            w_cnt_nxt = w_load_d;
            w_rld_nxt = w_load_d;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (bus.start) begin
          w_state_nxt = (r_cnt == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
        end else if (bus.en) begin
          if (w_cnt_one) begin
            if (bus.auto) begin
              w_cnt_nxt  = r_rld;
              w_bout_nxt = 1'b1;
            end else begin
              w_cnt_nxt   = '0;
              w_state_nxt = S_FIN;
            end
          end else if (!w_brw[DIGITS]) begin
            // top borrow-out means the count is zero: hold rather than wrap
            w_cnt_nxt = w_dec;
          end
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.cnt  = r_cnt;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.bout = r_bout;
  assign bus.err  = r_err;
endmodule
